fft_peak_detector: RTL and testbench

Streaming post-processor directly downstream of the 64-point FFT core's result readout. It accepts one complex bin per handshake (8-bit signed real/imag), computes an approximate magnitude per bin, and tracks the peak bin index, peak magnitude and summed magnitude over a 64-bin frame. It presents one result per frame on a valid/ready port and back-pressures the bin stream until that result has been consumed.

---
 rtl/fft_peak_detector.sv | 178 +++++++++++++++++
 tb/tb_fft_peak_detector.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_peak_detector.sv
// fft_peak_detector: streaming post-processor for 64-bin FFT frames.
// It computes an approximate magnitude for each bin, then tracks the peak
// bin, the peak magnitude and the summed magnitude across one frame. One
// result per frame is presented on a valid/ready port. The bin stream is
// back-pressured until that result has been consumed.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   ena                 global enable; all state freezes while low
//   frame_restart       discards the partial frame (ignored in HOLD)
//   skip_dc             excludes bin 0 from the peak search; sampled with bin 0
//   in_valid/in_ready   bin handshake; in_re/in_im are signed samples
//   peak_valid/ready    result handshake
//   peak_bin/peak_mag   index and magnitude of the peak bin
//   mag_sum             sum of all bin magnitudes in the frame
module fft_peak_detector #(
    localparam int unsigned N_BINS = 64,
    localparam int unsigned DW     = 8,
    localparam int unsigned IDX_W  = $clog2(N_BINS),
    localparam int unsigned MAG_W  = 8,
    localparam int unsigned SUM_W  = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 frame_restart,
    input  logic                 skip_dc,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_re,
    input  logic signed [DW-1:0] in_im,
    output logic                 peak_valid,
    input  logic                 peak_ready,
    output logic [IDX_W-1:0]     peak_bin,
    output logic [MAG_W-1:0]     peak_mag,
    output logic [SUM_W-1:0]     mag_sum
);

    typedef enum logic [1:0] {COLLECT, DRAIN, HOLD} state_t;

    state_t state, state_next;

    logic [IDX_W-1:0] bin_cnt;
    logic             p1_valid, p1_last, p1_consider, p2_last;
    logic [DW-1:0]    p1_re, p1_im;
    logic [IDX_W-1:0] p1_idx;
    logic             peak_seen;
    logic [IDX_W-1:0] pk_bin_acc;
    logic [MAG_W-1:0] pk_mag_acc;
    logic [SUM_W-1:0] sum_acc;

    logic             accept_c, last_c, clear_c, load_c, taken_c;
    logic [DW-1:0]    abs_re_c, abs_im_c, mx_c, mn_c;
    logic [MAG_W-1:0] mag_c;

    // This port name is fixed at the block boundary, so it keeps no _c suffix even though it is combinational.
    assign in_ready = rst_n & ena & (state == COLLECT) & ~frame_restart;
    assign accept_c = in_valid & in_ready;
    assign last_c   = (bin_cnt == IDX_W'(N_BINS - 1));
    assign taken_c  = peak_valid & peak_ready;

    // Unsigned absolute value: -128 maps to 128 in 8 bits.
    assign abs_re_c = in_re[DW-1] ? DW'(-in_re) : DW'(in_re);
    assign abs_im_c = in_im[DW-1] ? DW'(-in_im) : DW'(in_im);

    // mag = max + min/2 (peaks at 192, so it never overflows 8 bits)
    assign mx_c  = (p1_re >= p1_im) ? p1_re : p1_im;
    assign mn_c  = (p1_re >= p1_im) ? p1_im : p1_re;
    assign mag_c = MAG_W'(mx_c + (mn_c >> 1));

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else if (ena) begin
            state <= state_next;
        end
    end

    // Next state, frame clear and result load
    always_comb begin
        state_next = state;
        clear_c    = 1'b0;
        load_c     = 1'b0;
        case (state)
            COLLECT: begin
                if (frame_restart) begin
                    clear_c = 1'b1;
                end else if (accept_c && last_c) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (frame_restart) begin
                    clear_c    = 1'b1;
                    state_next = COLLECT;
                end else if (p2_last) begin
                    load_c     = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (taken_c) begin
                    clear_c    = 1'b1;
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    // Bin counter, P1 (abs values) and P2 (sum / peak accumulate)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_cnt     <= '0;
            p1_valid    <= 1'b0;
            p1_last     <= 1'b0;
            p1_consider <= 1'b0;
            p1_re       <= '0;
            p1_im       <= '0;
            p1_idx      <= '0;
            p2_last     <= 1'b0;
            peak_seen   <= 1'b0;
            pk_bin_acc  <= '0;
            pk_mag_acc  <= '0;
            sum_acc     <= '0;
        end else if (ena) begin
            if (clear_c) begin
                bin_cnt    <= '0;
                p1_valid   <= 1'b0;
                p2_last    <= 1'b0;
                peak_seen  <= 1'b0;
                pk_bin_acc <= '0;
                pk_mag_acc <= '0;
                sum_acc    <= '0;
            end else begin
                p1_valid <= accept_c;
                p2_last  <= p1_valid & p1_last;
                if (accept_c) begin
                    bin_cnt     <= bin_cnt + IDX_W'(1);
                    p1_re       <= abs_re_c;
                    p1_im       <= abs_im_c;
                    p1_idx      <= bin_cnt;
                    p1_last     <= last_c;
                    p1_consider <= !((bin_cnt == '0) && skip_dc);
                end
                if (p1_valid) begin
                    sum_acc <= sum_acc + SUM_W'(mag_c);
                    // Strictly-greater compare keeps the lowest index on ties.
                    if (p1_consider && (!peak_seen || (mag_c > pk_mag_acc))) begin
                        peak_seen  <= 1'b1;
                        pk_bin_acc <= p1_idx;
                        pk_mag_acc <= mag_c;
                    end
                end
            end
        end
    end

    // Result registers: loaded on entry to HOLD, valid dropped on handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            peak_valid <= 1'b0;
            peak_bin   <= '0;
            peak_mag   <= '0;
            mag_sum    <= '0;
        end else if (ena) begin
            if (load_c) begin
                peak_valid <= 1'b1;
                peak_bin   <= pk_bin_acc;
                peak_mag   <= pk_mag_acc;
                mag_sum    <= sum_acc;
            end else if (taken_c) begin
                peak_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fft_peak_detector.sv
// Directed testbench for fft_peak_detector. Expected frame results are pushed
// to a scoreboard queue. A monitor pops and compares them on each result handshake.
module tb_fft_peak_detector;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ena = 1'b1;
    logic              frame_restart = 1'b0;
    logic              skip_dc = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic signed [7:0] in_re = '0;
    logic signed [7:0] in_im = '0;
    logic              peak_valid;
    logic              peak_ready = 1'b1;
    logic [5:0]        peak_bin;
    logic [7:0]        peak_mag;
    logic [13:0]       mag_sum;

    typedef struct {
        logic [5:0]  b;
        logic [7:0]  m;
        logic [13:0] s;
    } exp_t;

    exp_t              sb[$];
    int                nvec = 0;
    int                errs = 0;
    int                results_seen = 0;
    logic signed [7:0] fr_re[64];
    logic signed [7:0] fr_im[64];

    fft_peak_detector dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena           (ena),
        .frame_restart (frame_restart),
        .skip_dc       (skip_dc),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_re         (in_re),
        .in_im         (in_im),
        .peak_valid    (peak_valid),
        .peak_ready    (peak_ready),
        .peak_bin      (peak_bin),
        .peak_mag      (peak_mag),
        .mag_sum       (mag_sum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [5:0] b, input logic [7:0] m, input logic [13:0] s);
        exp_t e;
        e.b = b;
        e.m = m;
        e.s = s;
        sb.push_back(e);
    endtask

    task automatic clear_frame(input logic signed [7:0] re, input logic signed [7:0] im);
        for (int i = 0; i < 64; i++) begin
            fr_re[i] = re;
            fr_im[i] = im;
        end
    endtask

    // Offer bins 0..n-1; with gaps, randomly drop in_valid or ena for a cycle.
    task automatic send_bins(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            bit acc;
            int budget;
            acc    = 1'b0;
            budget = 0;
            while (!acc) begin
                in_re    = fr_re[i];
                in_im    = fr_im[i];
                in_valid = 1'b1;
                ena      = 1'b1;
                if (gaps) begin
                    case ($urandom_range(0, 3))
                        0: in_valid = 1'b0;
                        1: ena = 1'b0;
                        default: ;
                    endcase
                end
                @(negedge clk);
                acc = in_valid && in_ready;
                step();
                budget++;
                if (!acc && budget > 200) begin
                    nvec++;
                    errs++;
                    $display("FAIL send_timeout: bin %0d not accepted, in_ready=%0d expected 1", i, in_ready);
                    in_valid = 1'b0;
                    ena      = 1'b1;
                    return;
                end
            end
        end
        in_valid = 1'b0;
        ena      = 1'b1;
    endtask

    task automatic wait_done(input int target);
        int b;
        b = 0;
        while (results_seen < target && b < 100) begin
            step();
            b++;
        end
        chk("result_handshake_count", 32'(results_seen), 32'(target));
    endtask

    // Monitor: compare the scoreboard head on each result handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && peak_valid && peak_ready) begin
                if (sb.size() == 0) begin
                    nvec++;
                    errs++;
                    $display("FAIL unexpected_result: bin %0d mag %0d sum %0d, expected none", peak_bin, peak_mag, mag_sum);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("peak_bin", 32'(peak_bin), 32'(e.b));
                    chk("peak_mag", 32'(peak_mag), 32'(e.m));
                    chk("mag_sum", 32'(mag_sum), 32'(e.s));
                end
                results_seen++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        // Reset
        repeat (3) step();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_peak_valid", 32'(peak_valid), 0);
        chk("rst_peak_bin", 32'(peak_bin), 0);
        chk("rst_peak_mag", 32'(peak_mag), 0);
        chk("rst_mag_sum", 32'(mag_sum), 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 1);

        // Frame A: bin5 (100,-40) -> 120, bin40 (-128,-128) -> 192
        clear_frame(8'sd0, 8'sd0);
        fr_re[5]  = 8'sd100;
        fr_im[5]  = -8'sd40;
        fr_re[40] = -8'sd128;
        fr_im[40] = -8'sd128;
        push_exp(6'd40, 8'd192, 14'd312);
        send_bins(64, 1'b0);
        chk("lat_k_peak_valid", 32'(peak_valid), 0);
        chk("lat_k_in_ready", 32'(in_ready), 0);
        step();
        chk("lat_k1_peak_valid", 32'(peak_valid), 0);
        step();
        chk("lat_k2_peak_valid", 32'(peak_valid), 1);
        step();
        chk("after_hs_in_ready", 32'(in_ready), 1);
        chk("after_hs_peak_valid", 32'(peak_valid), 0);
        wait_done(1);

        // Uniform (10,10): mag 15 each, sum 960
        clear_frame(8'sd10, 8'sd10);
        skip_dc = 1'b0;
        push_exp(6'd0, 8'd15, 14'd960);
        send_bins(64, 1'b0);
        wait_done(2);
        skip_dc = 1'b1;
        push_exp(6'd1, 8'd15, 14'd960);
        send_bins(64, 1'b0);
        wait_done(3);
        skip_dc = 1'b0;

        // Tie: bins 7 and 20 both (0,90)
        clear_frame(8'sd0, 8'sd0);
        fr_im[7]  = 8'sd90;
        fr_im[20] = 8'sd90;
        push_exp(6'd7, 8'd90, 14'd180);
        send_bins(64, 1'b0);
        wait_done(4);

        // Backpressure: only bin 63 (-3,7) -> mag 8
        clear_frame(8'sd0, 8'sd0);
        fr_re[63] = -8'sd3;
        fr_im[63] = 8'sd7;
        push_exp(6'd63, 8'd8, 14'd8);
        peak_ready = 1'b0;
        send_bins(64, 1'b0);
        step();
        step();
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_re    = 8'sd55;
            in_im    = -8'sd55;
            chk("hold_peak_valid", 32'(peak_valid), 1);
            chk("hold_in_ready", 32'(in_ready), 0);
            chk("hold_peak_bin", 32'(peak_bin), 63);
            chk("hold_peak_mag", 32'(peak_mag), 8);
            chk("hold_mag_sum", 32'(mag_sum), 8);
            step();
        end
        in_valid   = 1'b0;
        peak_ready = 1'b1;
        wait_done(5);
        chk("bp_release_in_ready", 32'(in_ready), 1);

        // frame_restart after 30 bins, plus a same-cycle in_valid beat
        clear_frame(8'sd100, 8'sd100);
        send_bins(30, 1'b0);
        frame_restart = 1'b1;
        in_valid      = 1'b1;
        in_re         = 8'sd127;
        in_im         = 8'sd127;
        @(negedge clk);
        chk("restart_in_ready", 32'(in_ready), 0);
        step();
        frame_restart = 1'b0;
        in_valid      = 1'b0;
        clear_frame(8'sd0, 8'sd0);
        fr_re[3] = 8'sd50;
        push_exp(6'd3, 8'd50, 14'd50);
        send_bins(64, 1'b0);
        wait_done(6);

        // Frame A again with random valid gaps and ena toggling
        clear_frame(8'sd0, 8'sd0);
        fr_re[5]  = 8'sd100;
        fr_im[5]  = -8'sd40;
        fr_re[40] = -8'sd128;
        fr_im[40] = -8'sd128;
        push_exp(6'd40, 8'd192, 14'd312);
        send_bins(64, 1'b1);
        wait_done(7);

        repeat (3) step();
        chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

endmodule
